// File: rtl/operand_entry_controller.sv
// Front-end operand entry: synchronizes switches and buttons, debounces the buttons,
// latches the switch operand on LOAD and steps the operation code on OP.

module operand_entry_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_i,
    output logic db_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s_i != db_q) begin
            if (cnt_q == CNT_MAX) db_d  = s_i;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o = db_q;
endmodule

module operand_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int NUM_OPS         = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] sw,
    input  logic       btn_load,
    input  logic       btn_op,
    input  logic       btn_clear,
    output logic [9:0] operand,
    output logic [2:0] curent_operation,
    output logic       operand_valid,
    output logic       load_pulse
);
    localparam int NUM_BTN = 3;
    localparam int B_LOAD  = 0;
    localparam int B_OP    = 1;
    localparam int B_CLEAR = 2;
    localparam logic [2:0] OP_MAX = 3'(NUM_OPS - 1);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    logic [9:0]         sw_meta_q, sw_sync_q;
    logic [NUM_BTN-1:0] btn_raw, btn_meta_q, btn_sync_q;
    logic [NUM_BTN-1:0] db, db_dly_q, press;

    state_t     state_q, state_d;
    logic [9:0] operand_q, operand_d;
    logic [2:0] op_q, op_d;
    logic       load_pulse_q, load_pulse_d;

    assign btn_raw = {btn_clear, btn_op, btn_load};

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        operand_entry_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst_n(reset_n),
            .s_i  (btn_sync_q[i]),
            .db_o (db[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db_dly_q <= '0;
        else          db_dly_q <= db;
    end

    // One press cycle per accepted rising level.
    assign press = db & ~db_dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (press[B_CLEAR])     state_d = EMPTY;
        else if (press[B_LOAD]) state_d = HELD;
    end

    always_comb begin
        operand_valid = (state_q == HELD);
    end

    // Clear dominates; load and op are independent of each other.
    always_comb begin
        operand_d    = operand_q;
        op_d         = op_q;
        load_pulse_d = 1'b0;
        if (press[B_CLEAR]) begin
            operand_d = '0;
            op_d      = '0;
        end else begin
            if (press[B_LOAD]) begin
                operand_d    = sw_sync_q;
                load_pulse_d = 1'b1;
            end
            if (press[B_OP]) op_d = (op_q == OP_MAX) ? 3'd0 : op_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_q    <= '0;
            op_q         <= '0;
            load_pulse_q <= 1'b0;
        end else begin
            operand_q    <= operand_d;
            op_q         <= op_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign operand          = operand_q;
    assign curent_operation = op_q;
    assign load_pulse       = load_pulse_q;
endmodule

// File: tb/tb_operand_entry_controller.sv
// Directed bench for operand_entry_controller with DEBOUNCE_CYCLES=4.

module tb_operand_entry_controller;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] sw = '0;
    logic       btn_load = 1'b0, btn_op = 1'b0, btn_clear = 1'b0;
    logic [9:0] operand;
    logic [2:0] curent_operation;
    logic       operand_valid, load_pulse;

    int vecs = 0;
    int errs = 0;

    operand_entry_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20),
        .NUM_OPS        (7)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sw              (sw),
        .btn_load        (btn_load),
        .btn_op          (btn_op),
        .btn_clear       (btn_clear),
        .operand         (operand),
        .curent_operation(curent_operation),
        .operand_valid   (operand_valid),
        .load_pulse      (load_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        btn_load  = 1'b0;
        btn_op    = 1'b0;
        btn_clear = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Holds the given buttons {clear,op,load} for n cycles then releases for 8;
    // returns the number of cycles load_pulse was seen high.
    task automatic press(input logic [2:0] b, input int n, output int lp_cnt);
        lp_cnt = 0;
        {btn_clear, btn_op, btn_load} = b;
        repeat (n) begin
            tick(1);
            if (load_pulse) lp_cnt++;
        end
        {btn_clear, btn_op, btn_load} = 3'b000;
        repeat (8) begin
            tick(1);
            if (load_pulse) lp_cnt++;
        end
    endtask

    task automatic test_reset();
        int lp_seen;
        do_reset();
        vecs++;
        if ({operand, curent_operation, operand_valid, load_pulse} !== 15'd0) begin
            errs++;
            $display("FAIL reset_state: got op=%h code=%0d valid=%b lp=%b, need all 0",
                     operand, curent_operation, operand_valid, load_pulse);
        end
        lp_seen = 0;
        repeat (20) begin
            tick(1);
            if (load_pulse || operand_valid || operand !== 10'd0 || curent_operation !== 3'd0)
                lp_seen++;
        end
        vecs++;
        if (lp_seen !== 0) begin
            errs++;
            $display("FAIL reset_idle: %0d cycles with nonzero outputs, need 0", lp_seen);
        end
    endtask

    task automatic test_clean_load();
        int lp_cnt;
        do_reset();
        sw = 10'h2A5;
        btn_load = 1'b1;
        tick(6);
        vecs++;
        if (operand !== 10'd0 || load_pulse !== 1'b0) begin
            errs++;
            $display("FAIL load_early: got op=%h lp=%b after edge 6, need 000 0", operand, load_pulse);
        end
        tick(1);
        vecs++;
        if (operand !== 10'h2A5 || operand_valid !== 1'b1 || load_pulse !== 1'b1) begin
            errs++;
            $display("FAIL load_edge7: got op=%h valid=%b lp=%b, need 2a5 1 1",
                     operand, operand_valid, load_pulse);
        end
        lp_cnt = 0;
        repeat (3) begin
            tick(1);
            if (load_pulse) lp_cnt++;
        end
        btn_load = 1'b0;
        repeat (8) begin
            tick(1);
            if (load_pulse) lp_cnt++;
        end
        vecs++;
        if (lp_cnt !== 0) begin
            errs++;
            $display("FAIL load_pulse_width: got %0d extra pulse cycles, need 0", lp_cnt);
        end
        sw = 10'h001;
        tick(6);
        vecs++;
        if (operand !== 10'h2A5 || operand_valid !== 1'b1 || load_pulse !== 1'b0) begin
            errs++;
            $display("FAIL load_hold_sw: got op=%h valid=%b lp=%b, need 2a5 1 0",
                     operand, operand_valid, load_pulse);
        end
        press(3'b001, 8, lp_cnt);
        vecs++;
        if (operand !== 10'h001 || lp_cnt !== 1) begin
            errs++;
            $display("FAIL reload: got op=%h pulses=%0d, need 001 1", operand, lp_cnt);
        end
    endtask

    task automatic test_bounce();
        int lp_cnt;
        do_reset();
        repeat (5) begin
            btn_op = 1'b1;
            tick(3);
            btn_op = 1'b0;
            tick(1);
        end
        tick(8);
        vecs++;
        if (curent_operation !== 3'd0) begin
            errs++;
            $display("FAIL bounce_reject: got code=%0d, need 0", curent_operation);
        end
        press(3'b010, 8, lp_cnt);
        vecs++;
        if (curent_operation !== 3'd1 || lp_cnt !== 0) begin
            errs++;
            $display("FAIL bounce_clean: got code=%0d pulses=%0d, need 1 0", curent_operation, lp_cnt);
        end
    endtask

    task automatic test_op_wrap();
        int lp_cnt;
        logic [2:0] expv [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            press(3'b010, 8, lp_cnt);
            vecs++;
            if (curent_operation !== expv[i]) begin
                errs++;
                $display("FAIL op_wrap[%0d]: got code=%0d, need %0d", i, curent_operation, expv[i]);
            end
        end
        press(3'b010, 50, lp_cnt);
        vecs++;
        if (curent_operation !== 3'd1) begin
            errs++;
            $display("FAIL op_hold: got code=%0d, need 1", curent_operation);
        end
    endtask

    task automatic test_simultaneous();
        int lp_cnt;
        do_reset();
        sw = 10'h2A5;
        press(3'b001, 8, lp_cnt);
        repeat (3) press(3'b010, 8, lp_cnt);
        vecs++;
        if (operand !== 10'h2A5 || curent_operation !== 3'd3 || operand_valid !== 1'b1) begin
            errs++;
            $display("FAIL simul_setup: got op=%h code=%0d valid=%b, need 2a5 3 1",
                     operand, curent_operation, operand_valid);
        end
        sw = 10'h3FF;
        press(3'b111, 8, lp_cnt);
        vecs++;
        if (operand !== 10'd0 || curent_operation !== 3'd0 || operand_valid !== 1'b0 || lp_cnt !== 0) begin
            errs++;
            $display("FAIL simul_clear: got op=%h code=%0d valid=%b pulses=%0d, need 000 0 0 0",
                     operand, curent_operation, operand_valid, lp_cnt);
        end
        sw = 10'h0F0;
        press(3'b011, 8, lp_cnt);
        vecs++;
        if (operand !== 10'h0F0 || curent_operation !== 3'd1 || operand_valid !== 1'b1 || lp_cnt !== 1) begin
            errs++;
            $display("FAIL simul_load_op: got op=%h code=%0d valid=%b pulses=%0d, need 0f0 1 1 1",
                     operand, curent_operation, operand_valid, lp_cnt);
        end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        sw = 10'h155;
        btn_load = 1'b1;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        vecs++;
        if (operand !== 10'd0 || operand_valid !== 1'b0 || load_pulse !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_early: got op=%h valid=%b lp=%b, need 000 0 0",
                     operand, operand_valid, load_pulse);
        end
        tick(1);
        vecs++;
        if (operand !== 10'h155 || operand_valid !== 1'b1 || load_pulse !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_load: got op=%h valid=%b lp=%b, need 155 1 1",
                     operand, operand_valid, load_pulse);
        end
        tick(1);
        vecs++;
        if (load_pulse !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_pulse: got lp=%b, need 0", load_pulse);
        end
        btn_load = 1'b0;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_bounce();
        test_op_wrap();
        test_simultaneous();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/operand_entry_controller.md
Name: operand_entry_controller

Overview:
- Front-end input block for the ALU board, feeding the display and ALU path.
- Synchronizes and debounces the push-buttons and synchronizes the 10 slide switches.
- Latches the switches into a registered operand on a LOAD press and steps the operation select on an OP press.
- Drives operand[9:0] and curent_operation[2:0], which the 7-segment display controller consumes.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized cycles before a button level is accepted (board build overrides to 500000).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- NUM_OPS, 7, number of operation codes; curent_operation cycles 0..NUM_OPS-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sw  in  10  raw slide switches (asynchronous).
- btn_load  in  1  raw LOAD button, active-high, bouncy.
- btn_op  in  1  raw OP-step button, active-high, bouncy.
- btn_clear  in  1  raw CLEAR button, active-high, bouncy.
- operand  out  10  latched operand, registered.
- curent_operation  out  3  current operation code, registered.
- operand_valid  out  1  high once an operand has been loaded since the last clear or reset.
- load_pulse  out  1  one-cycle strobe in the cycle operand takes a new value.

Behaviour:
- Reset (reset_n low, asynchronous): operand=0, curent_operation=0, operand_valid=0, load_pulse=0. Synchronizers, debounce counters, debounced levels and edge registers all clear to 0. Reset mid-debounce or mid-press discards that press; a button still held after release of reset must complete a full debounce before it is accepted.
- Synchronization: each button and each sw bit passes through 2 flops; the result is s.
- Debounce, per button:
  - Hold a debounced level db and counter cnt.
  - If s == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes db.
- Press detect: press = db & ~db_q, where db_q is db delayed by one register. This gives exactly one press cycle per accepted rising level; a held button produces no further presses, and release produces none.
- Latency: a raw button is first sampled high at edge 1. db is high after edge 2+DEBOUNCE_CYCLES. The affected outputs change after edge 3+DEBOUNCE_CYCLES.
- FSM states:
  - EMPTY: operand_valid=0.
  - HELD: operand_valid=1.
- Press actions, applied on the press cycle edge:
  - clear press: operand<=0, curent_operation<=0, go to EMPTY. Overrides load and op presses in the same cycle.
  - load press: operand<=synchronized sw, load_pulse<=1 for one cycle, go to HELD. Valid from EMPTY and from HELD; a reload overwrites the operand.
  - op press: curent_operation<=curent_operation+1, wrapping from NUM_OPS-1 to 0. Code 7 is never produced with the default NUM_OPS. Independent of FSM state.
  - load and op pressed in the same cycle: both take effect.
- Switch changes while in HELD do not alter operand until the next load press.
- load_pulse is registered, high for exactly one cycle, and coincides with the first cycle operand shows the new value.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4 for all):
- Reset then idle: reset_n low for 3 cycles, then release -> operand=0, curent_operation=0, operand_valid=0, load_pulse=0 held indefinitely.
- Clean load: sw=10'h2A5, btn_load high 10 cycles -> after edge 7, operand=10'h2A5, operand_valid=1, load_pulse high exactly one cycle. Changing sw to 10'h001 afterwards leaves operand=10'h2A5.
- Bounce rejection: btn_op toggled high 3 cycles, low 1 cycle, repeated 5 times -> curent_operation stays 0. A subsequent 8-cycle clean press -> curent_operation=1.
- Op wrap: 7 clean btn_op presses separated by 8 low cycles -> curent_operation sequence 1,2,3,4,5,6,0. Holding btn_op 50 cycles gives a single increment.
- Simultaneous events: in HELD with operand=10'h2A5 and op=3, press clear+load+op together -> operand=0, curent_operation=0, operand_valid=0, load_pulse=0. Then press load+op together with sw=10'h0F0 -> operand=10'h0F0, op=1, operand_valid=1.
- Reset mid-debounce: btn_load high, reset_n low at cycle 4 for 2 cycles, btn_load still high after release -> no load until 4 further stable cycles, then operand=sw and load_pulse pulses once.
